// File: rtl/pe_mac_pipe.sv
// ---------------------------------------------------------------------------
// pe_mac_pipe: three-stage fixed-point multiply-accumulate processing element
// with a 2**ADDR_W entry accumulator bank and a drain-then-clear sequencer.
//
//   S1 : latched operands (act, w, addr)
//   S2 : product = (act * w) >>> FRAC_W, reduced to DATA_W bits
//   S3 : sum = product + accumulator operand (forwarded from S3 when the
//        S3 address matches the S2 address); written to acc on next edge
//
// Ports
//   clk, rst_n           : clock (rising edge), async active-low reset
//   in_valid / in_ready  : operand handshake (in_ready low only while clearing)
//   in_act, in_w         : signed DATA_W operands, FRAC_W fractional bits
//   in_addr              : target accumulator address
//   acc_clear            : pulse, drains the pipeline then zeroes all entries
//   rd_en, rd_addr       : accumulator read request
//   rd_data              : registered read data (pre-edge value, no forwarding)
//   busy                 : any stage valid or clear sequence in progress
//
// Build option
//   PE_MAC_SAT_EN : when defined, the product and the sum saturate to the
//                   DATA_W signed range; otherwise they wrap (truncate).
// ---------------------------------------------------------------------------
module pe_mac_pipe #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_act,
  input  logic [DATA_W-1:0] in_w,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              acc_clear,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy
);

  localparam int DEPTH  = 2**ADDR_W;
  localparam int PROD_W = 2*DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

`ifdef PE_MAC_SAT_EN
  // Shifted product fits DATA_W only if all bits above the DATA_W sign bit
  // agree with it.
  function automatic logic [DATA_W-1:0] sat_prod(input logic signed [PROD_W-1:0] v);
    if (v[PROD_W-1:DATA_W-1] == {(PROD_W-DATA_W+1){v[PROD_W-1]}}) begin
      return v[DATA_W-1:0];
    end else if (v[PROD_W-1]) begin
      return {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end
  endfunction

  // One guard bit is enough for a DATA_W + DATA_W signed sum.
  function automatic logic [DATA_W-1:0] sat_sum(input logic signed [DATA_W:0] v);
    if (v[DATA_W] == v[DATA_W-1]) begin
      return v[DATA_W-1:0];
    end else if (v[DATA_W]) begin
      return {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end
  endfunction
`endif

  // Pipeline stages
  logic                     r_s1_valid, r_s2_valid, r_s3_valid;
  logic        [DATA_W-1:0] r_s1_act, r_s1_w;
  logic        [ADDR_W-1:0] r_s1_addr, r_s2_addr, r_s3_addr;
  logic        [DATA_W-1:0] r_s2_prod, r_s3_sum;

  // Sequencer and storage
  state_t                   r_state;
  logic                     r_in_ready;
  logic        [ADDR_W-1:0] r_clr_cnt;
  logic        [DATA_W-1:0] r_acc [DEPTH];
  logic        [DATA_W-1:0] r_rd_data;

  // Datapath wires
  logic                     w_accept;
  logic signed [PROD_W-1:0] w_act_ext, w_w_ext, w_prod_full, w_prod_shift;
  logic        [DATA_W-1:0] w_prod, w_operand, w_sum;
  logic                     w_fwd;

  assign w_accept = in_valid && r_in_ready;

  // Explicit sign extension keeps the multiply at full PROD_W precision.
  assign w_act_ext    = {{DATA_W{r_s1_act[DATA_W-1]}}, r_s1_act};
  assign w_w_ext      = {{DATA_W{r_s1_w[DATA_W-1]}}, r_s1_w};
  assign w_prod_full  = w_act_ext * w_w_ext;
  assign w_prod_shift = w_prod_full >>> FRAC_W;

  // The sum in S3 is not yet in acc, so a matching address must use it.
  assign w_fwd     = r_s3_valid && (r_s3_addr == r_s2_addr);
  assign w_operand = w_fwd ? r_s3_sum : r_acc[r_s2_addr];

`ifdef PE_MAC_SAT_EN
  logic signed [DATA_W:0] w_sum_wide;
  assign w_prod     = sat_prod(w_prod_shift);
  assign w_sum_wide = {r_s2_prod[DATA_W-1], r_s2_prod} + {w_operand[DATA_W-1], w_operand};
  assign w_sum      = sat_sum(w_sum_wide);
`else
  assign w_prod = DATA_W'(w_prod_shift);
  assign w_sum  = r_s2_prod + w_operand;
`endif

  assign in_ready = r_in_ready;
  assign rd_data  = r_rd_data;
  assign busy     = r_s1_valid | r_s2_valid | r_s3_valid | (r_state != ST_IDLE);

  // Three-stage MAC pipeline; stages advance every cycle without stalling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
      r_s1_act   <= {DATA_W{1'b0}};
      r_s1_w     <= {DATA_W{1'b0}};
      r_s1_addr  <= {ADDR_W{1'b0}};
      r_s2_addr  <= {ADDR_W{1'b0}};
      r_s3_addr  <= {ADDR_W{1'b0}};
      r_s2_prod  <= {DATA_W{1'b0}};
      r_s3_sum   <= {DATA_W{1'b0}};
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_act  <= in_act;
        r_s1_w    <= in_w;
        r_s1_addr <= in_addr;
      end
      r_s2_valid <= r_s1_valid;
      r_s2_prod  <= w_prod;
      r_s2_addr  <= r_s1_addr;
      r_s3_valid <= r_s2_valid;
      r_s3_sum   <= w_sum;
      r_s3_addr  <= r_s2_addr;
    end
  end

  // Clear sequencer: wait for the pipeline to empty, then sweep all entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b1;
      r_clr_cnt  <= {ADDR_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (acc_clear) begin
            r_state    <= ST_DRAIN;
            r_in_ready <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!r_s1_valid && !r_s2_valid && !r_s3_valid) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= {ADDR_W{1'b0}};
          end
        end
        ST_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (r_clr_cnt == {ADDR_W{1'b1}}) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  // Accumulator bank: clear sweep and S3 write-back never coincide because
  // the sweep only starts once the pipeline is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_acc[i] <= {DATA_W{1'b0}};
      end
    end else if (r_state == ST_CLEAR) begin
      r_acc[r_clr_cnt] <= {DATA_W{1'b0}};
    end else if (r_s3_valid) begin
      r_acc[r_s3_addr] <= r_s3_sum;
    end
  end

  // Read port: returns the stored (pre-edge) value, holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= {DATA_W{1'b0}};
    end else if (rd_en) begin
      r_rd_data <= r_acc[rd_addr];
    end
  end

endmodule

// File: tb/tb_pe_mac_pipe.sv
// Self-checking bench for pe_mac_pipe (default parameters). A transaction-level
// model keeps accumulators as plain integers: each accepted operand is applied
// to its entry three edges after acceptance, a clear request waits for all
// outstanding operands to retire and then zeroes one entry per edge.
module tb_pe_mac_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_act = 16'd0;
  logic [15:0] in_w = 16'd0;
  logic [5:0]  in_addr = 6'd0;
  logic        acc_clear = 1'b0;
  logic        rd_en = 1'b0;
  logic [5:0]  rd_addr = 6'd0;
  logic [15:0] rd_data;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;

  pe_mac_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_w(in_w), .in_addr(in_addr), .acc_clear(acc_clear),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int     addr;
    longint prod;
    longint due;
  } op_t;

  op_t    q[$];
  longint m_acc [64] = '{default: 0};
  longint m_rd = 0;
  longint m_n = 0;
  int     m_mode = 0;   // 0 idle, 1 waiting for pipeline to empty, 2 sweeping
  int     m_k = 0;
  bit     m_ready = 1'b1;
  bit     m_busy = 1'b0;
  bit     m_rdy_pre;

  function automatic longint fix(longint v);
`ifdef PE_MAC_SAT_EN
    if (v > 32767) return 32767;
    else if (v < -32768) return -32768;
    else return v;
`else
    longint t;
    t = v & 64'hFFFF;
    if (t >= 32768) t = t - 65536;
    return t;
`endif
  endfunction

  function automatic longint mprod(logic [15:0] a, logic [15:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return fix((sa * sb) >>> 8);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) m_acc[i] = 0;
      q.delete();
      m_rd = 0; m_n = 0; m_mode = 0; m_k = 0; m_ready = 1'b1; m_busy = 1'b0;
    end else begin
      m_rdy_pre = m_ready;
      m_n = m_n + 1;
      if (rd_en) m_rd = m_acc[rd_addr];
      case (m_mode)
        0: if (acc_clear) begin m_mode = 1; m_ready = 1'b0; end
        1: if (q.size() == 0) begin m_mode = 2; m_k = 0; end
        default: begin
          m_acc[m_k] = 0;
          if (m_k == 63) begin m_mode = 0; m_ready = 1'b1; end
          m_k = m_k + 1;
        end
      endcase
      while (q.size() > 0 && q[0].due == m_n) begin
        m_acc[q[0].addr] = fix(m_acc[q[0].addr] + q[0].prod);
        void'(q.pop_front());
      end
      if (in_valid && m_rdy_pre) q.push_back('{int'(in_addr), mprod(in_act, in_w), m_n + 3});
      m_busy = (q.size() > 0) || (m_mode != 0);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input bit ok, input string name, input longint got, input longint exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic drive_op(input logic [15:0] a, input logic [15:0] w, input logic [5:0] ad);
    in_valid = 1'b1; in_act = a; in_w = w; in_addr = ad;
    step();
    in_valid = 1'b0;
  endtask

  task automatic rd_check(input logic [5:0] ad, input logic [15:0] exp, input string name);
    rd_en = 1'b1; rd_addr = ad;
    step();
    rd_en = 1'b0;
    check(rd_data == exp, name, longint'(rd_data), longint'(exp));
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while ((!in_ready || busy) && c < 500) begin
      step();
      c++;
    end
    check(c < 500, "wait_idle_timeout", c, 500);
  endtask

  // ---------------- main ----------------
  initial begin
    fork
      begin : cmp
        forever begin
          @(negedge clk);
          if (rst_n) begin
            check(in_ready == m_ready, "in_ready", longint'(in_ready), longint'(m_ready));
            check(busy == m_busy, "busy", longint'(busy), longint'(m_busy));
            check(longint'($signed(rd_data)) == m_rd, "rd_data", longint'($signed(rd_data)), m_rd);
          end
        end
      end
      begin : stim
        int cnt;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check(in_ready == 1'b1, "rst_in_ready", longint'(in_ready), 1);
        check(busy == 1'b0, "rst_busy", longint'(busy), 0);
        check(rd_data == 16'h0000, "rst_rd_data", longint'(rd_data), 0);
        step();
        rst_n = 1'b1;
        step();

        // Single MAC: 2.0 * 1.5 = 3.0
        drive_op(16'h0200, 16'h0180, 6'd5);
        repeat (3) step();
        rd_check(6'd5, 16'h0300, "single_mac");
        check(m_acc[5] == 768, "model_single_mac", m_acc[5], 768);

        // Forwarding: four back-to-back 1.0*1.0 to one address
        for (int i = 0; i < 4; i++) begin
          check(in_ready == 1'b1, "fwd_in_ready", longint'(in_ready), 1);
          in_valid = 1'b1; in_act = 16'h0100; in_w = 16'h0100; in_addr = 6'd3;
          step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        rd_check(6'd3, 16'h0400, "forwarding");
        check(m_acc[3] == 1024, "model_forwarding", m_acc[3], 1024);

        // Saturation / truncation boundary
        drive_op(16'h7F00, 16'h7F00, 6'd0);
        drive_op(16'h7F00, 16'h7F00, 6'd0);
        repeat (3) step();
`ifdef PE_MAC_SAT_EN
        rd_check(6'd0, 16'h7FFF, "saturation");
        check(m_acc[0] == 32767, "model_saturation", m_acc[0], 32767);
`else
        rd_check(6'd0, 16'h0200, "truncation");
        check(m_acc[0] == 512, "model_truncation", m_acc[0], 512);
`endif

        // Randomized traffic with occasional clears
        for (int i = 0; i < 600; i++) begin
          in_valid  = ($urandom_range(0, 3) != 0);
          in_act    = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 1023) - 512);
          in_w      = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 1023) - 512);
          in_addr   = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 3)) : 6'($urandom);
          rd_en     = ($urandom_range(0, 1) == 1);
          rd_addr   = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 3)) : 6'($urandom);
          acc_clear = ($urandom_range(0, 79) == 0);
          step();
        end
        in_valid = 1'b0; rd_en = 1'b0; acc_clear = 1'b0;
        wait_idle();

        // Clear with two operands in flight
        drive_op(16'h0100, 16'h0200, 6'd10);
        acc_clear = 1'b1;
        drive_op(16'h0300, 16'h0100, 6'd11);
        acc_clear = 1'b0;
        rd_en = 1'b1; rd_addr = 6'd10;
        cnt = 0;
        while (!in_ready && cnt < 200) begin
          step();
          cnt++;
        end
        rd_en = 1'b0;
        check(cnt == 68, "clear_ready_low_cycles", cnt, 68);
        for (int a = 0; a < 64; a++) rd_check(6'(a), 16'h0000, "clear_zero");

        // Reset in the middle of the clear sweep (counter 20)
        wait_idle();
        drive_op(16'h0100, 16'h0100, 6'd40);
        repeat (4) step();
        acc_clear = 1'b1;
        step();
        acc_clear = 1'b0;
        repeat (21) step();
        rst_n = 1'b0;
        #1;
        check(in_ready == 1'b1, "midclear_rst_in_ready", longint'(in_ready), 1);
        check(busy == 1'b0, "midclear_rst_busy", longint'(busy), 0);
        check(rd_data == 16'h0000, "midclear_rst_rd_data", longint'(rd_data), 0);
        step();
        rst_n = 1'b1;
        step();
        for (int a = 0; a < 64; a++) rd_check(6'(a), 16'h0000, "post_reset_zero");
        check(in_ready == 1'b1, "post_reset_in_ready", longint'(in_ready), 1);
        drive_op(16'h0100, 16'h0300, 6'd7);
        repeat (3) step();
        rd_check(6'd7, 16'h0300, "post_reset_mac");
        step();
      end
    join_any
    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
